// File: rtl/rtl_xor_pipe.sv
// -----------------------------------------------------------------------------
// rtl_xor_pipe
//
// Elastic bitwise-operation pipeline. Each accepted beat is reduced to one
// result (XOR, XNOR, AND, or a running accumulated XOR). The result is captured
// into stage 0 and then carried through PIPE_STAGES register stages. Each stage
// holds a valid bit and its data. Valid/ready handshakes on both sides allow
// full throughput, and empty stages collapse under backpressure.
//
// Parameters
//   DATA_WIDTH   operand / result width in bits (>= 1)
//   PIPE_STAGES  register stages between acceptance and output (1..8)
//
// Ports
//   i__clk        sole clock, rising edge
//   i__areset     asynchronous, active-high reset
//   i__in_valid   producer presents a beat on i__inA/i__inB/i__mode/i__acc_clr
//   o__in_ready   block accepts the beat this cycle (no path from i__in_valid)
//   i__inA        operand A
//   i__inB        operand B
//   i__mode       0 XOR, 1 XNOR, 2 AND, 3 ACC (running XOR)
//   i__acc_clr    clears the accumulator (applied before an ACC beat's update)
//   o__out_valid  o__dout holds a valid result
//   i__out_ready  consumer takes the result this cycle
//   o__dout       result
// -----------------------------------------------------------------------------
module rtl_xor_pipe #(
    parameter int DATA_WIDTH  = 10,
    parameter int PIPE_STAGES = 2
) (
    input  logic                  i__clk,
    input  logic                  i__areset,
    input  logic                  i__in_valid,
    output logic                  o__in_ready,
    input  logic [DATA_WIDTH-1:0] i__inA,
    input  logic [DATA_WIDTH-1:0] i__inB,
    input  logic [1:0]            i__mode,
    input  logic                  i__acc_clr,
    output logic                  o__out_valid,
    input  logic                  i__out_ready,
    output logic [DATA_WIDTH-1:0] o__dout
);

    localparam int LAST = PIPE_STAGES - 1;

    typedef enum logic [1:0] {
        MODE_XOR  = 2'd0,
        MODE_XNOR = 2'd1,
        MODE_AND  = 2'd2,
        MODE_ACC  = 2'd3
    } mode_e;

    mode_e                  mode;
    logic                   accept;
    logic [DATA_WIDTH-1:0]  acc;
    logic [DATA_WIDTH-1:0]  acc_base;
    logic [DATA_WIDTH-1:0]  acc_next;
    logic [DATA_WIDTH-1:0]  result;

    logic [PIPE_STAGES-1:0] stage_valid;
    logic [PIPE_STAGES-1:0] stage_load;
    logic [DATA_WIDTH-1:0]  stage_data [PIPE_STAGES];

    assign mode     = mode_e'(i__mode);
    assign accept   = i__in_valid && o__in_ready;
    assign acc_base = i__acc_clr ? '0 : acc;
    assign acc_next = acc_base ^ i__inA ^ i__inB;

    // NOTE: every variable written in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        result = i__inA ^ i__inB;
        case (mode)
            MODE_XOR:  result = i__inA ^ i__inB;
            MODE_XNOR: result = ~(i__inA ^ i__inB);
            MODE_AND:  result = i__inA & i__inB;
            MODE_ACC:  result = acc_next;
            default:   result = i__inA ^ i__inB;
        endcase
    end

    // A stage may load when it is empty or when its own content moves on in
    // the same cycle. This ripples from the output back to the input, so
    // bubbles anywhere in the pipe are filled even while the output stalls,
    // and an occupied stage is never overwritten.
    always_comb begin
        stage_load       = '0;
        stage_load[LAST] = !stage_valid[LAST] || i__out_ready;
        for (int k = LAST - 1; k >= 0; k--) begin
            stage_load[k] = !stage_valid[k] || stage_load[k + 1];
        end
    end

    assign o__in_ready  = stage_load[0];
    assign o__out_valid = stage_valid[LAST];
    assign o__dout      = stage_data[LAST];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, whatever order the statements appear in.
    always_ff @(posedge i__clk or posedge i__areset) begin
        if (i__areset) begin
            acc <= '0;
        end else begin
            // acc_base already folds in the clear, so a non-ACC beat or an
            // idle cycle just stores it back.
            acc <= (accept && mode == MODE_ACC) ? acc_next : acc_base;
        end
    end

    // NOTE: the data registers are reset too (not only the valid bits), so
    // o__dout reads as zero right after reset instead of stale contents.
    always_ff @(posedge i__clk or posedge i__areset) begin
        if (i__areset) begin
            stage_valid <= '0;
            for (int k = 0; k < PIPE_STAGES; k++) begin
                stage_data[k] <= '0;
            end
        end else begin
            if (stage_load[0]) begin
                stage_valid[0] <= accept;
                if (accept) begin
                    stage_data[0] <= result;
                end
            end
            for (int k = 1; k < PIPE_STAGES; k++) begin
                if (stage_load[k]) begin
                    stage_valid[k] <= stage_valid[k - 1];
                    // Data only moves with a valid beat; a bubble leaves it alone.
                    if (stage_valid[k - 1]) begin
                        stage_data[k] <= stage_data[k - 1];
                    end
                end
            end
        end
    end

endmodule
